v2k_rr_arbiter: RTL

Round-robin arbiter that shares one registered (WIDTH+1)-bit capture stage between NREQ requesters. Each cycle it picks at most one pending requester, loads that requester's word into the shared output register, and presents the word downstream on a valid/ready handshake. It sits in front of the clocked register datapath, which consumes out_data. It provides fair, starvation-free access and back-to-back throughput.

---
 rtl/v2k_rr_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/v2k_rr_arbiter.sv
// Round-robin arbiter feeding one shared registered capture stage.
// One requester word is loaded per cycle, and the result is presented on a valid/ready handshake.
module v2k_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int SRCW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*(WIDTH+1)-1:0] req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH:0]            out_data,
  output logic [SRCW-1:0]           out_src
);

  localparam int W1 = WIDTH + 1;

  logic [W1-1:0]   slot [NREQ];
  logic            out_valid_q, out_valid_d;
  logic [W1-1:0]   out_data_q, out_data_d;
  logic [SRCW-1:0] out_src_q, out_src_d;
  logic [SRCW-1:0] ptr_q, ptr_d;

  logic            load;
  logic            found;
  logic            take;
  logic [SRCW-1:0] win;
  logic [SRCW-1:0] scan_idx;
  int              scan_sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = req_data[i*W1 +: W1];
  end

  // The register may accept a new word when it is empty or is draining in this same cycle.
  assign load = !out_valid_q || out_ready;

  // The scan starts at ptr and wraps modulo NREQ, so any value of NREQ works, not only powers of 2.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    scan_sum = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = int'(ptr_q) + k;
      if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
      scan_idx = SRCW'(scan_sum);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign take = !rst && load && found;

  always_comb begin
    gnt = '0;
    if (take) gnt[win] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = slot[win];
      out_src_d   = win;
      ptr_d       = (win == SRCW'(NREQ - 1)) ? '0 : win + SRCW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
